// File: rtl/pc_unit_ras_pkg.sv
// rtl/pc_unit_ras_pkg.sv - shared PC-source encodings for the fetch-stage PC unit
package pc_unit_ras_pkg;

    // Next-PC source select; codes 6 and 7 are unused and fall back to sequential fetch.
    typedef enum logic [2:0] {
        PC_DEFAULT = 3'd0,
        PC_IMM     = 3'd1,
        PC_SGN_IMM = 3'd2,
        PC_CALL    = 3'd3,
        PC_RET     = 3'd4,
        PC_REG     = 3'd5
    } pc_src_e;

    localparam int unsigned PC_SRC_W = 3;

endpackage

// File: rtl/pc_unit_ras_return_address_stack.sv
// rtl/pc_unit_ras_return_address_stack.sv - circular return-address stack with overflow/underflow pulses
module return_address_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic [PW-1:0]    w_top_inc;
    logic [PW-1:0]    w_top_dec;
    logic             w_full;
    logic             w_empty;

    // Pointer wrap is explicit so non-power-of-two depths stay in range.
    assign w_top_inc = (r_top == PW'(DEPTH - 1)) ? '0 : r_top + PW'(1);
    assign w_top_dec = (r_top == '0) ? PW'(DEPTH - 1) : r_top - PW'(1);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);

    assign pop_data  = r_mem[r_top];
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // Entry storage: a push when full lands on the oldest slot, which silently drops it.
    always_ff @(posedge clock) begin
        if (push) begin
            r_mem[w_top_inc] <= push_data;
        end
    end

    // Top pointer, occupancy and one-cycle status pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_top       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= push && w_full;
            r_underflow <= pop && w_empty;
            if (push) begin
                r_top <= w_top_inc;
                if (!w_full) begin
                    r_count <= r_count + CW'(1);
                end
            end else if (pop && !w_empty) begin
                r_top   <= w_top_dec;
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - fetch PC register with next-PC select and return-address stack
module pc_unit_ras
    import pc_unit_ras_pkg::*;
#(
    parameter int                  PC_WIDTH     = 16,
    parameter int                  RAS_DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0] PC_STEP      = PC_WIDTH'(1),
    localparam int                 CW           = $clog2(RAS_DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                stall,
    input  logic [2:0]          sig_pc_src,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] I_TypeImmediate,
    input  logic [PC_WIDTH-1:0] J_TypeImmediate,
    input  logic [PC_WIDTH-1:0] reg_target,
    input  logic [PC_WIDTH-1:0] R7,
    output logic [PC_WIDTH-1:0] PC,
    output logic [CW-1:0]       ras_count,
    output logic                ras_overflow,
    output logic                ras_underflow
);

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_seq;
    logic [PC_WIDTH-1:0] w_pc_jimm;
    logic [PC_WIDTH-1:0] w_pc_iimm;
    logic [PC_WIDTH-1:0] w_ras_top;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic [CW-1:0]       w_ras_count;
    logic                w_push;
    logic                w_pop;

    // Truncating adds give the modulo-2^PC_WIDTH wrap for free.
    assign w_pc_seq  = r_pc + PC_STEP;
    assign w_pc_jimm = r_pc + J_TypeImmediate;
    assign w_pc_iimm = r_pc + I_TypeImmediate;

    assign w_push = !stall && (sig_pc_src == PC_CALL);
    assign w_pop  = !stall && (sig_pc_src == PC_RET);

    return_address_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_seq),
        .pop_data  (w_ras_top),
        .count     (w_ras_count),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    // Next-PC select; an empty stack falls back to R7 on return.
    always_comb begin
        w_next_pc = w_pc_seq;
        case (pc_src_e'(sig_pc_src))
            PC_IMM:     w_next_pc = w_pc_jimm;
            PC_SGN_IMM: w_next_pc = branch_taken ? w_pc_iimm : w_pc_seq;
            PC_CALL:    w_next_pc = w_pc_jimm;
            PC_RET:     w_next_pc = (w_ras_count == '0) ? R7 : w_ras_top;
            PC_REG:     w_next_pc = reg_target;
            default:    w_next_pc = w_pc_seq;
        endcase
    end

    // Fetch PC register, frozen while stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= RESET_VECTOR;
        end else if (!stall) begin
            r_pc <= w_next_pc;
        end
    end

    assign PC        = r_pc;
    assign ras_count = w_ras_count;

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - self-checking bench for pc_unit_ras against a queue-based model
module tb_pc_unit_ras;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic          clock;
    logic          reset_n;
    logic          stall;
    logic [2:0]    sig_pc_src;
    logic          branch_taken;
    logic [W-1:0]  I_TypeImmediate;
    logic [W-1:0]  J_TypeImmediate;
    logic [W-1:0]  reg_target;
    logic [W-1:0]  R7;
    logic [W-1:0]  PC;
    logic [2:0]    ras_count;
    logic          ras_overflow;
    logic          ras_underflow;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_pc;
    logic [W-1:0] ras_q[$];
    logic         exp_ovf;
    logic         exp_unf;

    pc_unit_ras #(
        .PC_WIDTH     (W),
        .RAS_DEPTH    (DEPTH),
        .RESET_VECTOR (16'd0),
        .PC_STEP      (16'd1)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .stall           (stall),
        .sig_pc_src      (sig_pc_src),
        .branch_taken    (branch_taken),
        .I_TypeImmediate (I_TypeImmediate),
        .J_TypeImmediate (J_TypeImmediate),
        .reg_target      (reg_target),
        .R7              (R7),
        .PC              (PC),
        .ras_count       (ras_count),
        .ras_overflow    (ras_overflow),
        .ras_underflow   (ras_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("pc", 32'(PC), 32'(exp_pc));
        chk("ras_count", 32'(ras_count), 32'(ras_q.size()));
        chk("ras_overflow", 32'(ras_overflow), 32'(exp_ovf));
        chk("ras_underflow", 32'(ras_underflow), 32'(exp_unf));
    endtask

    // Drive one cycle of inputs, advance the model by the architectural rules, compare after the edge.
    task automatic step(input logic st, input logic [2:0] src, input logic bt,
                        input logic [W-1:0] ii, input logic [W-1:0] jj,
                        input logic [W-1:0] rt, input logic [W-1:0] r7v);
        stall = st; sig_pc_src = src; branch_taken = bt;
        I_TypeImmediate = ii; J_TypeImmediate = jj; reg_target = rt; R7 = r7v;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        if (!st) begin
            case (src)
                3'd1: exp_pc = exp_pc + jj;
                3'd2: exp_pc = bt ? exp_pc + ii : exp_pc + 16'd1;
                3'd3: begin
                    if (ras_q.size() == DEPTH) begin
                        ras_q.delete(0);
                        exp_ovf = 1'b1;
                    end
                    ras_q.push_back(exp_pc + 16'd1);
                    exp_pc = exp_pc + jj;
                end
                3'd4: begin
                    if (ras_q.size() > 0) exp_pc = ras_q.pop_back();
                    else begin
                        exp_pc = r7v;
                        exp_unf = 1'b1;
                    end
                end
                3'd5: exp_pc = rt;
                default: exp_pc = exp_pc + 16'd1;
            endcase
        end
        @(posedge clock);
        #1;
        check_model();
    endtask

    task automatic go(input logic [2:0] src, input logic [W-1:0] jj);
        step(1'b0, src, 1'b0, 16'd0, jj, 16'd0, 16'd0);
    endtask

    task automatic go_reg(input logic [W-1:0] rt);
        step(1'b0, 3'd5, 1'b0, 16'd0, 16'd0, rt, 16'd0);
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; sig_pc_src = 3'd0; branch_taken = 1'b0;
        I_TypeImmediate = '0; J_TypeImmediate = '0; reg_target = '0; R7 = '0;
        exp_pc = 16'd0; exp_ovf = 1'b0; exp_unf = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_model();
        chk("reset_pc", 32'(PC), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Sequential fetch 0 -> 3
        repeat (3) go(3'd0, 16'd0);
        chk("seq_pc3", 32'(PC), 32'd3);

        // Call then return
        go(3'd3, 16'd10);
        chk("call_pc13", 32'(PC), 32'd13);
        chk("call_count1", 32'(ras_count), 32'd1);
        go(3'd4, 16'd0);
        chk("ret_pc4", 32'(PC), 32'd4);

        // Call chain of five overflows a depth-4 stack
        go_reg(16'd0);
        for (int i = 0; i < 5; i++) go(3'd3, 16'd2);
        chk("chain_ovf", 32'(ras_overflow), 32'd1);
        chk("chain_count4", 32'(ras_count), 32'd4);
        go(3'd4, 16'd0);
        chk("ret_newest9", 32'(PC), 32'd9);
        chk("ovf_one_cycle", 32'(ras_overflow), 32'd0);
        for (int i = 0; i < 3; i++) go(3'd4, 16'd0);
        chk("ret_oldest3", 32'(PC), 32'd3);
        step(1'b0, 3'd4, 1'b0, 16'd0, 16'd0, 16'd0, 16'd100);
        chk("ret_r7", 32'(PC), 32'd100);
        chk("unf_pulse", 32'(ras_underflow), 32'd1);

        // Conditional branch and negative jump
        go_reg(16'd20);
        step(1'b0, 3'd2, 1'b0, 16'd8, 16'd0, 16'd0, 16'd0);
        chk("br_not_taken", 32'(PC), 32'd21);
        go_reg(16'd21);
        step(1'b0, 3'd2, 1'b1, 16'd8, 16'd0, 16'd0, 16'd0);
        chk("br_taken", 32'(PC), 32'd29);
        go(3'd1, -16'sd10);
        chk("jmp_neg", 32'(PC), 32'd19);

        // Wrap-around
        go_reg(16'hFFFF);
        go(3'd0, 16'd0);
        chk("wrap_inc", 32'(PC), 32'd0);
        go_reg(16'd2);
        go(3'd1, -16'sd5);
        chk("wrap_neg", 32'(PC), 32'hFFFD);

        // Stall freezes everything
        go(3'd3, 16'd4);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd3, 1'b1, 16'd7, 16'd9, 16'd5, 16'd6);
        chk("stall_count", 32'(ras_count), 32'd1);

        // Async reset mid-chain
        go(3'd3, 16'd4);
        go(3'd3, 16'd4);
        chk("chain3", 32'(ras_count), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_pc", 32'(PC), 32'd0);
        chk("areset_count", 32'(ras_count), 32'd0);
        exp_pc = 16'd0; ras_q.delete(); exp_ovf = 1'b0; exp_unf = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [2:0]   s;
            logic [W-1:0] ii, jj;
            s  = 3'($urandom_range(0, 7));
            ii = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 40)) - 16'd20;
            jj = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 40)) - 16'd20;
            step($urandom_range(0, 7) == 0, s, 1'($urandom), ii, jj, W'($urandom), W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
